// File: rtl/tick_ctrl_pkg.sv
// Shared definitions for the countdown-timer control stage and other board-level blocks.
package tick_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEF_CLK_HZ          = 100_000_000;
    localparam int unsigned DEF_TICK_HZ         = 1;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_ctrl_btn_debounce.sv
// Push-button debouncer: two-flop synchroniser, stability counter, one-cycle press pulse.
module btn_debounce
    import tick_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;

    // Accepted level resets to "pressed" so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            level   <= 1'b1;
            press   <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            press   <= 1'b0;
            if (r_sync2 == level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tick_ctrl.sv
// Countdown-timer control: debounced start/load buttons, run/pause/done FSM and 1 Hz CE prescaler.
module tick_ctrl
    import tick_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ         = DEF_TICK_HZ,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_start,
    input  logic btn_load,
    input  logic done,
    input  logic error,
    output logic CE,
    output logic load,
    output logic running,
    output logic paused
);

    localparam int unsigned   DIV     = CLK_HZ / TICK_HZ;
    localparam int unsigned   PW      = cnt_width(DIV);
    localparam logic [PW-1:0] CNT_MAX = PW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("tick_ctrl: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic          w_start_press;
    logic          w_load_press;
    logic          w_unused_start_level;
    logic          w_unused_load_level;

    state_e        r_state;
    state_e        w_next_state;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt_nxt;
    logic          w_ce_nxt;
    logic          w_load_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_start),
        .level  (w_unused_start_level),
        .press  (w_start_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_load),
        .level  (w_unused_load_level),
        .press  (w_load_press)
    );

    // Next state, prescaler and pulse decisions; CE only when staying in RUN.
    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        w_ce_nxt     = 1'b0;
        w_load_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_load_press) begin
                    w_load_nxt = 1'b1;
                end else if (w_start_press) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + PW'(1);
                if (done || error) begin
                    w_next_state = ST_DONE;
                end else if (w_start_press) begin
                    w_next_state = ST_PAUSE;
                end else begin
                    w_ce_nxt = (r_cnt == CNT_MAX);
                end
            end
            ST_PAUSE: begin
                if (w_load_press) begin
                    w_load_nxt   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_start_press) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_load_press) begin
                    w_load_nxt   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            CE      <= 1'b0;
            load    <= 1'b0;
            running <= 1'b0;
            paused  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
            CE      <= w_ce_nxt;
            load    <= w_load_nxt;
            running <= (w_next_state == ST_RUN);
            paused  <= (w_next_state == ST_PAUSE);
        end
    end

endmodule

// File: tb/tb_tick_ctrl.sv
// Scoreboard bench for tick_ctrl: expected CE/load pulses are queued with their cycle, a monitor pops them.
module tb_tick_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic btn_start;
    logic btn_load;
    logic done;
    logic error;
    logic CE;
    logic load;
    logic running;
    logic paused;

    typedef struct packed {
        logic is_load;
        int   cyc;
    } pulse_t;

    pulse_t exp_q[$];
    int     cyc     = 0;
    int     n_check = 0;
    int     n_fail  = 0;

    tick_ctrl #(
        .CLK_HZ          (10),
        .TICK_HZ         (1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_load  (btn_load),
        .done      (done),
        .error     (error),
        .CE        (CE),
        .load      (load),
        .running   (running),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the queue in kind and cycle.
    always @(negedge clk) begin
        pulse_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_check++;
            n_fail++;
            $display("FAIL missed_pulse: expected %s at cycle %0d, still absent at cycle %0d",
                     e.is_load ? "load" : "CE", e.cyc, cyc);
        end
        if (CE && load) begin
            n_check++;
            n_fail++;
            $display("FAIL ce_load_overlap: CE=1 and load=1 together at cycle %0d", cyc);
        end
        if (CE || load) begin
            n_check++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got %s at cycle %0d, expected none",
                         load ? "load" : "CE", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_load != load || e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got %s at cycle %0d, expected %s at cycle %0d",
                             load ? "load" : "CE", cyc, e.is_load ? "load" : "CE", e.cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic act, input logic exp);
        n_check++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic is_load, input int at);
        pulse_t e;
        e.is_load = is_load;
        e.cyc     = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Clean press from cycle N: FSM acts on edge N+7; held 8 cycles then released and settled.
    task automatic press(input logic s, input logic l, input logic raise_done,
                         input logic exp_run, input logic exp_pause, input string nm);
        btn_start = s;
        btn_load  = l;
        repeat (6) @(negedge clk);
        if (raise_done) done = 1'b1;
        @(negedge clk);
        check({nm, "_running"}, running, exp_run);
        check({nm, "_paused"}, paused, exp_pause);
        @(negedge clk);
        btn_start = 1'b0;
        btn_load  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e;
        int r;
        reset     = 1'b1;
        btn_start = 1'b0;
        btn_load  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ce", CE, 1'b0);
        check("rst_load", load, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_paused", paused, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Bouncing start button: 2-cycle glitches are rejected.
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            repeat (2) @(negedge clk);
        end
        btn_start = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_running", running, 1'b0);
        check("bounce_paused", paused, 1'b0);

        // Start from IDLE; CE every 10 cycles starting 10 after RUN entry.
        n = cyc;
        e = n + 7;
        push(1'b0, e + 10);
        push(1'b0, e + 20);
        push(1'b0, e + 30);
        press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "start");

        // Pause with the prescaler at 6, hold 50 cycles, resume: CE 3 cycles later.
        wait_until(e + 30);
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "pause");
        repeat (50) @(negedge clk);
        check("pause_hold_paused", paused, 1'b1);
        check("pause_hold_ce", CE, 1'b0);
        n = cyc;
        r = n + 7;
        push(1'b0, r + 3);
        push(1'b0, r + 13);
        press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "resume");

        // done together with start in RUN: done wins.
        press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "done_vs_start");
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "done_start_ignored");
        n = cyc;
        push(1'b1, n + 7);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "done_load");
        done = 1'b0;

        // load beats start in IDLE; load ignored in RUN.
        n = cyc;
        push(1'b1, n + 7);
        press(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "both_idle");
        n = cyc;
        e = n + 7;
        push(1'b0, e + 10);
        push(1'b0, e + 20);
        press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "start_after_load");
        press(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "load_in_run");

        // Reset in RUN with the prescaler at 9: no CE, everything low.
        wait_until(e + 29);
        reset = 1'b1;
        @(negedge clk);
        check("rst_run_ce", CE, 1'b0);
        check("rst_run_load", load, 1'b0);
        check("rst_run_running", running, 1'b0);
        check("rst_run_paused", paused, 1'b0);

        // Button held through reset gives no press until re-pressed.
        btn_start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("held_rst_running", running, 1'b0);
        btn_start = 1'b0;
        repeat (10) @(negedge clk);
        check("held_rst_released_running", running, 1'b0);
        n = cyc;
        e = n + 7;
        press(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "repress");

        // error on the edge where the prescaler is at 9: exit to DONE, CE suppressed.
        error = 1'b1;
        @(negedge clk);
        check("error_running", running, 1'b0);
        check("error_ce", CE, 1'b0);
        error = 1'b0;
        n = cyc;
        push(1'b1, n + 7);
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "error_load");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size() == 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
